// File: rtl/mul_div_sequencer.sv
// Iterative unsigned MULTU/DIVU unit with the HI/LO register pair.
// One shift-add or restoring-divide step per cycle; MTHI/MTLO complete in one cycle.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
  logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand / divisor
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier / quotient (dividend bits shift out)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;

    mul_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_q, mplier_q[WIDTH-1]};
    // Remainder is always below the divisor, so bit WIDTH of the trial is the borrow.
    div_trial = div_shift - {1'b0, mcand_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        dz_d    = 1'b0;
        if (start) begin
          case (op)
            OP_MULTU: begin
              acc_d    = '0;
              mcand_d  = b;
              mplier_d = a;
              count_d  = CW'(WIDTH - 1);
              state_d  = S_MUL;
            end
            OP_DIVU: begin
              acc_d    = '0;
              mcand_d  = b;
              mplier_d = a;
              count_d  = CW'(WIDTH - 1);
              dz_d     = (b == '0);
              state_d  = S_DIV;
            end
            OP_MTHI: hi_d = a;
            default: lo_d = a;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = mul_sum[WIDTH:1];
        mplier_d = {mul_sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q - 1'b1;
        if (count_q == '0) begin
          hi_d    = acc_d;
          lo_d    = mplier_d;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (dz_q) begin
          hi_d    = mplier_q;
          lo_d    = '1;
          state_d = S_DONE;
        end else begin
          if (!div_trial[WIDTH]) begin
            acc_d    = div_trial[WIDTH-1:0];
            mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d    = div_shift[WIDTH-1:0];
            mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            hi_d    = acc_d;
            lo_d    = mplier_d;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = done && dz_q;
  assign stall       = busy && (rd_hilo || start);
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: directed cases plus random ops scored against
// plain 64-bit arithmetic results.
module tb_mul_div_sequencer;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rd_hilo;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] cur_hilo;

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .stall(stall), .hi(hi), .lo(lo)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    if (o == 2'b00) r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == '0) r = {x, {W{1'b1}}};
    else r = {x % y, x / y};
    return r;
  endfunction

  // Called at the negedge just after the accepting edge, with start already low.
  task automatic wait_result(input int n_exp, input logic dz_exp);
    int n = 0;
    logic held = 1'b1;
    logic [2*W-1:0] exp;
    while (busy === 1'b1 && n < W + 4) begin
      if ({hi, lo} !== cur_hilo) held = 1'b0;
      n++;
      @(negedge clk);
    end
    check_eq("busy_cycles", 64'(n), 64'(n_exp));
    check_eq("hilo_held", 64'(held), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("div_by_zero", 64'(div_by_zero), 64'(dz_exp));
    check_eq("result_hilo", {hi, lo}, exp);
    cur_hilo = exp;
    @(negedge clk);
    check_eq("done_drop", 64'({done, busy, div_by_zero}), 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (o == 2'b10) begin
      cur_hilo[2*W-1:W] = x;
      check_eq("mthi", {hi, lo}, cur_hilo);
      check_eq("mthi_quiet", 64'({busy, done}), 64'd0);
    end else if (o == 2'b11) begin
      cur_hilo[W-1:0] = x;
      check_eq("mtlo", {hi, lo}, cur_hilo);
      check_eq("mtlo_quiet", 64'({busy, done}), 64'd0);
    end else begin
      exp_q.push_back(ref_result(o, x, y));
      wait_result((o == 2'b01 && y == '0) ? 1 : W, (o == 2'b01 && y == '0));
    end
  endtask

  initial begin
    logic stall_ok;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    int n;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_hilo = 1'b0;
    cur_hilo = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_hilo", {hi, lo}, '0);
    check_eq("reset_flags", 64'({busy, done, div_by_zero, stall}), 64'd0);
    rst_n = 1'b1;

    issue(2'b00, 32'd7, 32'd6);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("mul_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(2'b01, 32'd100, 32'd7);
    check_eq("div_100_7", {hi, lo}, {32'd2, 32'd14});
    issue(2'b01, 32'd5, 32'd0);
    check_eq("div_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h1234_5678;
    @(negedge clk);
    check_eq("mthi_b2b", {hi, lo}, {32'h1234_5678, cur_hilo[W-1:0]});
    op = 2'b11; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check_eq("mtlo_b2b", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    check_eq("mt_busy", 64'(busy), 64'd0);
    cur_hilo = {32'h1234_5678, 32'h9ABC_DEF0};

    // stall while busy, ignored start, re-issue accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    rd_hilo = 1'b1; start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd9;
    #1;
    check_eq("stall_raise", 64'(stall), 64'd1);
    stall_ok = 1'b1;
    while (busy === 1'b1 && n < W + 4) begin
      if (stall !== 1'b1 || {hi, lo} !== cur_hilo) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq("stall_hold", 64'(stall_ok), 64'd1);
    check_eq("stall_busy_len", 64'(n - 1), 64'(W));
    check_eq("stall_done_cycle", 64'({stall, done}), 64'b01);
    check_eq("stall_mul_result", {hi, lo}, 64'd143);
    cur_hilo = 64'd143;
    @(negedge clk);
    start = 1'b0; rd_hilo = 1'b0;
    exp_q.push_back({32'd1000 % 32'd9, 32'd1000 / 32'd9});
    wait_result(W, 1'b0);

    // reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_hilo", {hi, lo}, '0);
    check_eq("midreset_flags", 64'({busy, done, div_by_zero}), 64'd0);
    cur_hilo = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'd3, 32'd3);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      issue(ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
